// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads get the slot they need, writer fills the rest.
// Optional macro VGA_ARB_WR_GUARD_EN: out-of-range writes are acked, dropped and flagged on wr_err.
module vga_fb_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int H_OFF  = 64,
    parameter int V_OFF  = 16,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_display,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    output logic              data_ready,
    output logic [DATA_W-1:0] pixel,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_data_ready;
    logic [DATA_W-1:0] r_pixel;

    logic [9:0]        w_rd_x;
    logic [9:0]        w_rd_y;
    logic              w_rd_in_range;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_issue;
    logic              w_wr_grant;
    logic              w_wr_bad;
    logic              w_wr_commit;

    // Counters below the offsets wrap to large values and fall out of range naturally.
    assign w_rd_x        = counter_x - 10'(H_OFF);
    assign w_rd_y        = counter_y - 10'(V_OFF);
    assign w_rd_in_range = (32'(w_rd_x) < 32'(H_ACT)) && (32'(w_rd_y) < 32'(V_ACT));
    assign w_rd_addr     = ADDR_W'(w_rd_y) * ADDR_W'(H_ACT) + ADDR_W'(w_rd_x);

    assign w_rd_issue = rst_n && (r_state == IDLE) && in_display && w_rd_in_range;
    assign w_wr_grant = rst_n && wr_req &&
                        (((r_state == IDLE) && !in_display) || (r_state == SETTLE));

`ifdef VGA_ARB_WR_GUARD_EN
    localparam longint unsigned FB_SIZE = longint'(H_ACT) * longint'(V_ACT);

    logic r_wr_err;

    assign w_wr_bad = (64'(wr_addr) >= 64'(FB_SIZE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (w_wr_grant && w_wr_bad) begin
            r_wr_err <= 1'b1;
        end
    end

    assign wr_err = r_wr_err;
`else
    assign w_wr_bad = 1'b0;
    assign wr_err   = 1'b0;
`endif

    assign w_wr_commit = w_wr_grant && !w_wr_bad;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (w_rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = w_rd_addr;
        end else if (w_wr_commit) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end
    end

    assign wr_ack = w_wr_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_data_ready <= 1'b0;
            r_pixel      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_data_ready <= 1'b0;
                    if (in_display) begin
                        if (w_rd_in_range) begin
                            r_state <= RD_WAIT;
                            r_cnt   <= 2'(RD_LAT);
                        end else begin
                            // Off-screen coordinates still need a pulse so the generator advances.
                            r_pixel      <= '0;
                            r_data_ready <= 1'b1;
                            r_state      <= SETTLE;
                        end
                    end
                end
                RD_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        r_pixel      <= mem_rdata;
                        r_data_ready <= 1'b1;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_data_ready <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_data_ready <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign data_ready = r_data_ready;
    assign pixel      = r_pixel;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port frame-buffer arbiter between the VGA display read path and a pixel writer (image-processing side). It schedules one read per displayed pixel from the timing generator's counters and returns a one-cycle data_ready pulse that advances the generator. Writes are granted in all memory slots the display does not need. Sits between the VGA timing generator, the frame-buffer RAM and the writer.

Parameters:
ADDR_W, 19, frame-buffer address width
DATA_W, 8, pixel width
RD_LAT, 1, RAM read latency in cycles (legal 1..3)
H_OFF, 64, first active counter_x value
V_OFF, 16, first active counter_y value
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame

Ports:
clk  in  1  system clock
rst_n  in  1  reset
in_display  in  1  display-area flag from timing generator
counter_x  in  10  horizontal counter
counter_y  in  10  vertical counter
data_ready  out  1  pixel-valid pulse to timing generator
pixel  out  DATA_W  current display pixel
wr_req  in  1  write request, held with wr_addr/wr_data until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  write granted this cycle
wr_err  out  1  sticky out-of-range write flag
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Single clock clk; rst_n synchronous, active-low.
- Reset: state IDLE, data_ready=0, pixel=0, wr_err=0, wait counter=0; mem_en/mem_we/wr_ack=0 while rst_n=0. Reset mid-read aborts it; no data_ready for that read.
- FSM: IDLE, RD_WAIT, SETTLE. data_ready and pixel are registered; mem_* and wr_ack are combinational from state and inputs.
- rd_x = counter_x-H_OFF, rd_y = counter_y-V_OFF (10-bit). rd_addr = rd_y*H_ACT+rd_x, mod 2^ADDR_W.
- IDLE, in_display=1, rd_x<H_ACT and rd_y<V_ACT: mem_en=1, mem_we=0, mem_addr=rd_addr. Go to RD_WAIT with counter=RD_LAT.
- IDLE, in_display=1, coordinates out of range: no RAM access; pixel<=0; go to SETTLE.
- RD_WAIT: decrement counter each cycle. On last cycle (counter=1): pixel<=mem_rdata, data_ready<=1, go to SETTLE. Read issued in cycle t gives data_ready high in cycle t+RD_LAT+1.
- SETTLE: data_ready=1 for exactly this cycle; next state IDLE. Timing counters advance here.
- Write grant: in IDLE with in_display=0, or in any SETTLE cycle, and wr_req=1. Grant drives wr_ack=1, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle; state unchanged.
- Priority: a display read beats a write in IDLE. Writes never stall display reads.
- Blanking (in_display=0): one write per cycle sustained. data_ready stays 0 and pixel holds its last value.
- No RAM access in RD_WAIT. Otherwise mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care.

Optional Feature:
VGA_ARB_WR_GUARD_EN defined: a granted write with wr_addr >= H_ACT*V_ACT is acked (wr_ack=1) but not committed (mem_we=0, mem_en=0). wr_err<=1 and stays set until reset. Undefined: every granted write commits unconditionally and wr_err is tied 0.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_display=1, wr_req=1 -> data_ready=0, wr_ack=0, mem_en=0, pixel=0. Assert reset in RD_WAIT -> no data_ready afterwards.
- Read, RD_LAT=2: in_display=1, x=64, y=16 -> mem_addr=0 in issue cycle. mem_rdata=0xA5 -> data_ready high 1 cycle at issue+3, pixel=0xA5. x=703, y=495 -> mem_addr=307199.
- Contention: in_display=1, wr_req=1 in IDLE -> read issued first. Write acked in the SETTLE cycle (mem_we=1, mem_addr=wr_addr, wr_ack=1).
- Blanking: in_display=0, 4 back-to-back writes (addr 0..3, data 0x11..0x44) -> wr_ack high 4 consecutive cycles, data_ready=0 throughout.
- Out of range: in_display=1, x=10, y=20 -> mem_en=0, data_ready pulses next cycle, pixel=0.
- Guard: wr_addr=307200, macro on -> wr_ack=1, mem_we=0, wr_err=1 held until reset. Macro off -> mem_we=1, wr_err=0.
